// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, ALU encodings,
// decoded instruction classes and the sequencer state encoding.
package cpu_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_JMP  = 5'b00110;
    localparam logic [4:0] OP_JZ   = 5'b00111;
    localparam logic [4:0] OP_HALT = 5'b01000;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;

    typedef enum logic [2:0] {
        CL_NOP, CL_LDI, CL_ALU, CL_JMP, CL_JZ, CL_HALT, CL_ILL
    } op_class_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
    } state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decode: register-file/ALU fields and the
// instruction class the sequencer branches on.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  alu_op,
    output logic [2:0]  rd_sel,
    output logic [2:0]  rs_sel,
    output logic [7:0]  imm,
    output logic        src_imm,
    output op_class_t   op_class
);

    assign rd_sel  = ir[10:8];
    assign rs_sel  = ir[7:5];
    assign imm     = ir[7:0];
    assign src_imm = (op_class == CL_LDI);

    always_comb begin
        alu_op   = ALU_NONE;
        op_class = CL_ILL;
        case (ir[15:11])
            OP_NOP:  op_class = CL_NOP;
            OP_LDI:  op_class = CL_LDI;
            OP_ADD:  begin op_class = CL_ALU; alu_op = ALU_ADD; end
            OP_SUB:  begin op_class = CL_ALU; alu_op = ALU_SUB; end
            OP_AND:  begin op_class = CL_ALU; alu_op = ALU_AND; end
            OP_OR:   begin op_class = CL_ALU; alu_op = ALU_OR;  end
            OP_JMP:  op_class = CL_JMP;
            OP_JZ:   op_class = CL_JZ;
            OP_HALT: op_class = CL_HALT;
            default: op_class = CL_ILL;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multicycle control sequencer: owns PC and IR, fetches over the RAM
// handshake and strobes register-file / flag writes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for en_in at an instruction boundary
// S_FETCH  | en_ram_in high, waiting for en_ram_out (bounded by TIMEOUT)
// S_DECODE | IR valid, illegal opcodes flagged
// S_EXEC   | branches resolved, pc updated for non-writing instructions
// S_WB     | register write (and flag write for ALU ops), pc+1
// S_HALT   | HALT executed, terminal until rst
// S_ERR    | fetch timed out, terminal until rst
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic              en_ram_out,
    input  logic [15:0]       ins,
    input  logic              zero,
    output logic              en_ram_in,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        alu_op,
    output logic [2:0]        rd_sel,
    output logic [2:0]        rs_sel,
    output logic [7:0]        imm,
    output logic              src_imm,
    output logic              reg_we,
    output logic              flag_we,
    output logic              halted,
    output logic              err,
    output logic              illegal
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            state, state_nxt, boundary;
    op_class_t         op_class;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, pc_jmp;
    logic [15:0]       ir;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ir_load;

    cpu_decode u_decode (
        .ir       (ir),
        .alu_op   (alu_op),
        .rd_sel   (rd_sel),
        .rs_sel   (rs_sel),
        .imm      (imm),
        .src_imm  (src_imm),
        .op_class (op_class)
    );

    assign pc_inc   = pc + ADDR_W'(1);
    assign pc_jmp   = ADDR_W'(imm);
    assign boundary = en_in ? S_FETCH : S_IDLE;
    assign addr     = pc;
    assign halted   = (state == S_HALT) || (state == S_ERR);
    assign err      = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
            if (ir_load) ir <= ins;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        ir_load   = 1'b0;
        en_ram_in = 1'b0;
        reg_we    = 1'b0;
        flag_we   = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_IDLE: if (en_in) state_nxt = S_FETCH;
            S_FETCH: begin
                en_ram_in = 1'b1;
                if (en_ram_out) begin
                    ir_load   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_DECODE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = S_ERR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                illegal   = (op_class == CL_ILL);
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (op_class)
                    CL_LDI, CL_ALU: state_nxt = S_WB;
                    CL_JMP: begin pc_nxt = pc_jmp; state_nxt = boundary; end
                    CL_JZ: begin
                        pc_nxt    = zero ? pc_jmp : pc_inc;
                        state_nxt = boundary;
                    end
                    CL_HALT: state_nxt = S_HALT;
                    default: begin pc_nxt = pc_inc; state_nxt = boundary; end
                endcase
            end
            S_WB: begin
                reg_we    = 1'b1;
                flag_we   = (op_class == CL_ALU);
                pc_nxt    = pc_inc;
                state_nxt = boundary;
            end
            S_HALT, S_ERR: state_nxt = state;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
